// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment driver. It holds a snapshot of an N-digit BCD
// bus and its decimal points, then drives one digit at a time onto a shared
// segment bus. It adds dead-time between digits, leading-zero blanking, a dash
// for non-decimal codes, and a pulse at the end of each frame.
// Every output is registered, so each output lags the scan counters by one cycle.
module seg_scan_driver #(
  parameter int N_DIGITS       = 4,
  parameter int SCAN_DIV       = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int BLANK_LZ       = 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        load,
  input  logic [4*N_DIGITS-1:0]       bcd_in,
  input  logic [N_DIGITS-1:0]         dp_in,
  output logic [6:0]                  seg,
  output logic                        dp,
  output logic [N_DIGITS-1:0]         an_n,
  output logic [$clog2(N_DIGITS)-1:0] digit_idx,
  output logic                        frame_done
);

  localparam int IW = $clog2(N_DIGITS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(N_DIGITS - 1);

  logic [4*N_DIGITS-1:0] snap_bcd;
  logic [N_DIGITS-1:0]   snap_dp;
  logic [PW-1:0]         p;
  logic [IW-1:0]         i;

  logic [3:0]          cur_code;
  logic                blank;
  logic [6:0]          seg_on;
  logic [6:0]          seg_nxt;
  logic                dp_nxt;
  logic [N_DIGITS-1:0] an_nxt;

  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  // Select the current digit. Blank it if it and every digit above it are zero.
  // A non-decimal code counts as non-zero here.
  always_comb begin
    logic all_zero;
    cur_code = snap_bcd[int'(i)*4 +: 4];
    all_zero = 1'b1;
    blank    = 1'b0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      all_zero = all_zero & (snap_bcd[4*k +: 4] == 4'd0);
      if ((k == int'(i)) && (k != 0)) blank = all_zero & (BLANK_LZ != 0);
    end
    seg_on  = blank ? 7'h00 : decode(cur_code);
    seg_nxt = (SEG_ACTIVE_LOW != 0) ? ~seg_on : seg_on;
    dp_nxt  = (SEG_ACTIVE_LOW != 0) ? ~snap_dp[i] : snap_dp[i];
    an_nxt  = (p == '0) ? '1 : ~({{(N_DIGITS-1){1'b0}}, 1'b1} << i);
  end

  // Snapshot register. A load may happen at any time and never disturbs the scan.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      snap_bcd <= '0;
      snap_dp  <= '0;
    end else if (load) begin
      snap_bcd <= bcd_in;
      snap_dp  <= dp_in;
    end
  end

  // Dwell prescaler and digit index.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      p <= '0;
      i <= '0;
    end else if (p == P_LAST) begin
      p <= '0;
      i <= (i == I_LAST) ? '0 : i + 1'b1;
    end else begin
      p <= p + 1'b1;
    end
  end

  // Registered outputs, driven from the counter values and snapshot of the previous cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      seg        <= SEG_OFF;
      dp         <= DP_OFF;
      an_n       <= '1;
      digit_idx  <= '0;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      an_n       <= an_nxt;
      digit_idx  <= i;
      frame_done <= (i == I_LAST) && (p == P_LAST);
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver. It runs two instances side by side: one with
// leading-zero blanking and one without. A behavioural model derives the
// expected outputs from the number of cycles since reset and from a copy of
// the loaded digits.
module tb_seg_scan_driver;
  localparam int N  = 4;
  localparam int SD = 4;
  localparam int FR = N * SD;

  logic        clk = 1'b0;
  logic        rstn;
  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;

  logic [6:0] seg0, seg1;
  logic       dp0, dp1;
  logic [3:0] an0, an1;
  logic [1:0] idx0, idx1;
  logic       fd0, fd1;

  seg_scan_driver #(.N_DIGITS(N), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1), .BLANK_LZ(1)) dut (
    .clk(clk), .rstn(rstn), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .seg(seg0), .dp(dp0), .an_n(an0), .digit_idx(idx0), .frame_done(fd0));

  seg_scan_driver #(.N_DIGITS(N), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1), .BLANK_LZ(0)) dut_nolz (
    .clk(clk), .rstn(rstn), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .seg(seg1), .dp(dp1), .an_n(an1), .digit_idx(idx1), .frame_done(fd1));

  always #5 clk = ~clk;

  // Reference model.
  int         k;
  int         dig [N];
  bit         dpm [N];
  int         hex [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                           'h7F, 'h6F, 'h40, 'h40, 'h40, 'h40, 'h40, 'h40};
  logic [3:0] e_an;
  logic [6:0] e_seg, e_seg1;
  logic       e_dp;
  logic [1:0] e_idx;
  logic       e_fd;

  wire [21:0] got = {an0, seg0, dp0, idx0, fd0, seg1};
  wire [21:0] exp_v = {e_an, e_seg, e_dp, e_idx, e_fd, e_seg1};

  int n_checks = 0;
  int n_fail   = 0;

  always @(posedge clk) begin
    int  pp, ii;
    bit  lit;
    if (!rstn) begin
      k = 0;
      for (int j = 0; j < N; j++) begin dig[j] = 0; dpm[j] = 0; end
      e_an = 4'hF; e_seg = 7'h7F; e_seg1 = 7'h7F; e_dp = 1'b1; e_idx = 0; e_fd = 0;
    end else begin
      pp = k % SD;
      ii = (k / SD) % N;
      lit = (ii == 0);
      for (int j = ii; j < N; j++) if (dig[j] != 0) lit = 1;
      e_an   = (pp == 0) ? 4'hF : ~(4'(1) << ii);
      e_seg1 = ~7'(hex[dig[ii]]);
      e_seg  = lit ? e_seg1 : 7'h7F;
      e_dp   = ~dpm[ii];
      e_idx  = 2'(ii);
      e_fd   = ((k % FR) == FR - 1);
      k++;
      if (load) for (int j = 0; j < N; j++) begin
        dig[j] = int'(bcd_in[4*j +: 4]);
        dpm[j] = dp_in[j];
      end
    end
  end

  task automatic test_reset();
    rstn = 0; load = 0; bcd_in = 0; dp_in = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({an0, seg0, dp0, fd0, an1, seg1} !== {4'hF, 7'h7F, 1'b1, 1'b0, 4'hF, 7'h7F}) begin
        n_fail++;
        $display("FAIL reset_values c=%0d got an=%b seg=%h dp=%b fd=%b want an=1111 seg=7f dp=1 fd=0",
                 c, an0, seg0, dp0, fd0);
      end
    end
    rstn = 1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL reset_release c=%0d got=%h want=%h", c, got, exp_v);
      end
      if (c >= 2 && c <= 4) begin
        n_checks++;
        if ({an0, seg0} !== {4'b1110, 7'h40}) begin
          n_fail++; $display("FAIL release_digit0 c=%0d got an=%b seg=%h want an=1110 seg=40", c, an0, seg0);
        end
      end
    end
  endtask

  task automatic test_scan();
    int pulses = 0;
    bcd_in = 16'h1234; dp_in = 0; load = 1;
    @(posedge clk); #1; load = 0;
    for (int c = 0; c < 2 * FR; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL scan c=%0d got=%h want=%h", c, got, exp_v);
      end
      if (fd0) pulses++;
    end
    n_checks++;
    if (pulses !== 2) begin
      n_fail++; $display("FAIL frame_done_count got=%0d want=2", pulses);
    end
  endtask

  task automatic test_decode();
    bcd_in = 16'hF9A8; dp_in = 4'b0000; load = 1;
    @(posedge clk); #1; load = 0;
    for (int c = 0; c < FR + 2; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL decode c=%0d got=%h want=%h", c, got, exp_v);
      end
    end
  endtask

  task automatic test_blank();
    logic [15:0] pats [3] = '{16'h0007, 16'h0000, 16'h0A00};
    for (int t = 0; t < 3; t++) begin
      bcd_in = pats[t]; dp_in = 4'b1010; load = 1;
      @(posedge clk); #1; load = 0;
      for (int c = 0; c < FR + 2; c++) begin
        @(posedge clk); #1;
        n_checks++;
        if (got !== exp_v) begin
          n_fail++; $display("FAIL blank pat=%h c=%0d got=%h want=%h", pats[t], c, got, exp_v);
        end
      end
    end
  endtask

  task automatic test_midframe();
    int guard = 0;
    bcd_in = 16'h1111; dp_in = 0; load = 1;
    @(posedge clk); #1; load = 0;
    while ((k % FR) != 5 && guard < 2 * FR) begin
      @(posedge clk); #1; guard++;
      n_checks++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL midframe_pre g=%0d got=%h want=%h", guard, got, exp_v);
      end
    end
    n_checks++;
    if (guard >= 2 * FR) begin
      n_fail++; $display("FAIL midframe_align got k=%0d want k%%%0d=5", k, FR);
    end
    bcd_in = 16'h2222; dp_in = 4'b0010; load = 1;
    for (int c = 0; c < FR + 4; c++) begin
      @(posedge clk); #1; load = 0;
      n_checks++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL midframe c=%0d got=%h want=%h", c, got, exp_v);
      end
    end
  endtask

  task automatic test_counter_reset();
    int cnt = 0;
    int guard = 0;
    load = 1; dp_in = 0; bcd_in = 0;
    for (int c = 0; c < 3 * FR; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL counter c=%0d got=%h want=%h", c, got, exp_v);
      end
      cnt = (cnt + 1) % 10;
      bcd_in = 16'(cnt);
    end
    while ((k % FR) != 9 && guard < 2 * FR) begin
      @(posedge clk); #1; guard++;
    end
    rstn = 0;
    @(posedge clk); #1;
    n_checks++;
    if ({an0, seg0, dp0, idx0, fd0} !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
      n_fail++; $display("FAIL reset_midscan got an=%b seg=%h dp=%b idx=%0d fd=%b want an=1111 seg=7f dp=1 idx=0 fd=0",
                         an0, seg0, dp0, idx0, fd0);
    end
    rstn = 1;
    for (int c = 0; c < FR + 4; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL restart c=%0d got=%h want=%h", c, got, exp_v);
      end
      cnt = (cnt + 1) % 10;
      bcd_in = 16'(cnt);
    end
    load = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      load   = ($urandom_range(3) == 0);
      bcd_in = 16'($urandom);
      if ($urandom_range(1) == 0) bcd_in[15:8] = 8'h00;
      dp_in  = 4'($urandom);
      @(posedge clk); #1;
      n_checks++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL random c=%0d got=%h want=%h", c, got, exp_v);
      end
    end
    load = 0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_decode();
    test_blank();
    test_midframe();
    test_counter_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
